// File: rtl/stuff_or_data_pkg.sv
// -----------------------------------------------------------------------------
// stuff_or_data_pkg
// Shared definitions for the GMP mapper/demapper pair: the default field and
// payload widths, and the demapper frame-tracking state encoding.
// -----------------------------------------------------------------------------
package stuff_or_data_pkg;

    // Default width of the pm/cm fields and of the slot counters.
    localparam int MPT_W_DEF  = 8;
    // Default width of one payload word.
    localparam int DATA_W_DEF = 8;

    // ST_IDLE: waiting for a start-of-frame slot.
    // ST_RUN : inside a frame, or just finished one and expecting sof next.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/gmp_sd_acc.sv
// -----------------------------------------------------------------------------
// gmp_sd_acc
// Sigma-delta data/stuff decision shared by the GMP mapper and demapper.
// Each stepped slot adds cm to the accumulator; when the sum reaches pm the
// slot carries data and pm is subtracted back out. Over pm slots this yields
// exactly cm data slots, evenly spread, and returns the accumulator to 0.
//
// Ports
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the accumulator
//   pm    : slots per frame in effect for this slot
//   cm    : data words per frame in effect for this slot
//   step  : advance the accumulator by one slot
//   clear : treat the accumulator as 0 for this slot (frame start)
//   ds    : 1 = this slot is data, 0 = stuff (meaningful only with step)
//   acc   : registered accumulator value
// -----------------------------------------------------------------------------
module gmp_sd_acc
    import stuff_or_data_pkg::*;
#(
    parameter int MPT_W = MPT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MPT_W-1:0] pm,
    input  logic [MPT_W-1:0] cm,
    input  logic             step,
    input  logic             clear,
    output logic             ds,
    output logic [MPT_W-1:0] acc
);

    logic [MPT_W-1:0] acc_q;
    logic [MPT_W-1:0] acc_d;
    logic [MPT_W-1:0] base;
    logic [MPT_W:0]   sum;

    always_comb begin
        // The start slot of a frame is decided against a zero accumulator.
        base = clear ? '0 : acc_q;
        // One extra bit so acc + cm never wraps before the comparison.
        sum  = {1'b0, base} + {1'b0, cm};
        ds   = (sum >= {1'b0, pm});
        // acc stays below pm, so both results fit in MPT_W bits; the data
        // case is computed modulo 2^MPT_W, which gives the same low bits.
        acc_d = base;
        if (step) begin
            acc_d = ds ? (sum[MPT_W-1:0] - pm) : sum[MPT_W-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/gmp_demapper.sv
// -----------------------------------------------------------------------------
// gmp_demapper
// Extracts GMP payload words from a stream of slots. The frame configuration
// (pm slots, cm data words) is captured on the sof slot; gmp_sd_acc then marks
// each slot as data or stuff, and data slots are forwarded with one cycle of
// latency. Frame-alignment and configuration problems are flagged as pulses.
//
// Ports
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   pm, cm        : slots / data words per frame, sampled with sof
//   valid_in      : a slot is present this cycle
//   sof           : first slot of a frame (qualified by valid_in)
//   din           : slot content (data or stuff)
//   dout          : extracted data word, holds between data slots
//   dout_valid    : dout carries a new word this cycle
//   sof_out       : marks the first data word of a frame
//   frame_done    : pulse with the last slot of a frame
//   err_sof_early : sof arrived before the current frame completed
//   err_sof_late  : frame completed but the next slot carried no sof
//   cfg_err       : sof with pm = 0 or cm > pm; slot discarded
// -----------------------------------------------------------------------------
module gmp_demapper
    import stuff_or_data_pkg::*;
#(
    parameter int MPT_W  = MPT_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MPT_W-1:0]  pm,
    input  logic [MPT_W-1:0]  cm,
    input  logic              valid_in,
    input  logic              sof,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              sof_out,
    output logic              frame_done,
    output logic              err_sof_early,
    output logic              err_sof_late,
    output logic              cfg_err
);

    localparam logic [MPT_W-1:0] SLOT_ONE = {{(MPT_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [MPT_W-1:0]  slot_q, slot_d;          // slots consumed in this frame
    logic [MPT_W-1:0]  pm_q, pm_d;
    logic [MPT_W-1:0]  cm_q, cm_d;
    logic              first_q, first_d;        // no data word emitted yet
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              sof_out_q, sof_out_d;
    logic              frame_done_q, frame_done_d;
    logic              err_early_q, err_early_d;
    logic              err_late_q, err_late_d;
    logic              cfg_err_q, cfg_err_d;

    // Control decisions for the current slot, fed to the accumulator.
    logic              start;
    logic              step;
    logic              clear;
    logic              first_eff;
    logic [MPT_W-1:0]  eff_pm;
    logic [MPT_W-1:0]  eff_cm;
    logic              ds;
    logic [MPT_W-1:0]  acc_unused;

    wire cfg_ok = (pm != '0) && (cm <= pm);

    gmp_sd_acc #(
        .MPT_W (MPT_W)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .pm    (eff_pm),
        .cm    (eff_cm),
        .step  (step),
        .clear (clear),
        .ds    (ds),
        .acc   (acc_unused)
    );

    // Frame control. Kept free of ds so the accumulator's combinational
    // decision does not loop back into the block that drives its inputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned and no latch is inferred.
        state_d     = state_q;
        slot_d      = slot_q;
        pm_d        = pm_q;
        cm_d        = cm_q;
        err_early_d = 1'b0;
        err_late_d  = 1'b0;
        cfg_err_d   = 1'b0;
        start       = 1'b0;
        step        = 1'b0;
        clear       = 1'b0;
        first_eff   = first_q;
        eff_pm      = pm_q;
        eff_cm      = cm_q;

        if (valid_in) begin
            case (state_q)
                ST_IDLE: begin
                    // Slots without sof are dropped while unaligned.
                    start = sof;
                end
                ST_RUN: begin
                    if (slot_q == pm_q) begin
                        // Previous frame complete: this slot must open a new one.
                        if (sof) begin
                            start = 1'b1;
                        end else begin
                            err_late_d = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end else if (sof) begin
                        // Abandon the partial frame and resync on this slot.
                        err_early_d = 1'b1;
                        start       = 1'b1;
                    end else begin
                        step   = 1'b1;
                        slot_d = slot_q + SLOT_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (start) begin
                if (cfg_ok) begin
                    pm_d      = pm;
                    cm_d      = cm;
                    eff_pm    = pm;
                    eff_cm    = cm;
                    clear     = 1'b1;
                    step      = 1'b1;
                    slot_d    = SLOT_ONE;
                    first_eff = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    cfg_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
        end
    end

    // Output datapath for a stepped slot.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sof_out_d    = 1'b0;
        frame_done_d = 1'b0;
        first_d      = first_q;

        if (step) begin
            if (ds) begin
                dout_d       = din;
                dout_valid_d = 1'b1;
                sof_out_d    = first_eff;
            end
            first_d      = first_eff & ~ds;
            frame_done_d = (slot_d == eff_pm);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            slot_q       <= '0;
            pm_q         <= '0;
            cm_q         <= '0;
            first_q      <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sof_out_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_early_q  <= 1'b0;
            err_late_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            pm_q         <= pm_d;
            cm_q         <= cm_d;
            first_q      <= first_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sof_out_q    <= sof_out_d;
            frame_done_q <= frame_done_d;
            err_early_q  <= err_early_d;
            err_late_q   <= err_late_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;
    assign sof_out       = sof_out_q;
    assign frame_done    = frame_done_q;
    assign err_sof_early = err_early_q;
    assign err_sof_late  = err_late_q;
    assign cfg_err       = cfg_err_q;

endmodule

// File: doc/gmp_demapper.md
GMP_DEMAPPER -- requirements
Module: gmp_demapper

Interface
REQ-001 SHALL have parameter MPT_W, default 8, the width of the pm/cm fields and slot counters.
REQ-002 SHALL have parameter DATA_W, default 8, the width of the payload word.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port pm, input, MPT_W bits: slots per frame, sampled at frame start.
REQ-006 SHALL have port cm, input, MPT_W bits: data words per frame, sampled at frame start.
REQ-007 SHALL have ports valid_in (input, 1 bit, slot present this cycle) and sof (input, 1 bit, qualified by valid_in, first slot of frame).
REQ-008 SHALL have port din, input, DATA_W bits: slot content, data or stuff.
REQ-009 SHALL have outputs dout (DATA_W bits, extracted data word), dout_valid (1 bit) and sof_out (1 bit, marks the first data word of a frame).
REQ-010 SHALL have 1-bit pulse outputs frame_done, err_sof_early, err_sof_late and cfg_err.

Function
REQ-011 SHALL ignore cycles with valid_in=0: no state, counter or accumulator change, and all pulse outputs low on the next cycle.
REQ-012 SHALL implement states IDLE (wait for sof) and RUN (inside frame).
REQ-013 In IDLE, valid_in & sof with 0<pm and cm<=pm SHALL latch pm/cm into pm_r/cm_r, clear acc, treat the slot as slot 1 and enter RUN.
REQ-014 In IDLE, valid_in & sof with pm=0 or cm>pm SHALL pulse cfg_err, discard the slot and remain in IDLE.
REQ-015 In IDLE, valid_in without sof SHALL discard the slot silently.
REQ-016 Per valid slot SHALL compute s = acc + cm_r at MPT_W+1 bits; when s>=pm_r the slot is data and acc<=s-pm_r; otherwise it is stuff and acc<=s.
REQ-017 Over pm_r slots, REQ-016 SHALL yield exactly cm_r data slots and return acc to 0.
REQ-018 For a data slot, dout<=din and dout_valid<=1 on the next cycle (latency 1); stuff slots SHALL leave dout_valid=0 and dout holding its value.
REQ-019 sof_out SHALL be high with the first dout_valid of each frame only.
REQ-020 On slot pm_r, frame_done SHALL pulse with the same registered timing, and the block SHALL stay in RUN expecting sof on the next valid slot.
REQ-021 In RUN after slot pm_r, a valid slot with sof SHALL start a new frame per REQ-013/014.
REQ-022 In RUN after slot pm_r, a valid slot without sof SHALL pulse err_sof_late, discard the slot and enter IDLE.
REQ-023 In RUN, sof on slot index < pm_r SHALL pulse err_sof_early, abandon the current frame without frame_done, and process this slot as slot 1 of a new frame per REQ-013/014.
REQ-024 cm_r=0 SHALL produce no dout_valid and still pulse frame_done; cm_r=pm_r SHALL mark every slot as data.

Reset
REQ-025 rst=1 SHALL, on the next clock edge and regardless of state, force IDLE and clear acc, slot counter, pm_r, cm_r, dout, dout_valid, sof_out, frame_done and all error outputs to 0.
REQ-026 A frame in progress when rst is asserted SHALL be lost; after reset, the block SHALL require a fresh sof.

Structure
REQ-027 Package stuff_or_data_pkg SHALL hold the state enum and the default widths MPT_W/DATA_W, shared with the mapper side.
REQ-028 The data/stuff decision of REQ-016 SHALL be a sub-module gmp_sd_acc (inputs pm, cm, step, clear; outputs ds, acc) so that mapper and demapper produce identical decisions.
REQ-029 Control and output registers SHALL live in gmp_demapper; there are no other sub-modules.

Verification
REQ-030 pm=8, cm=3, 8 contiguous valid slots din=1..8 with sof on slot 1 -> dout_valid for din 3,6,8; sof_out with 3; frame_done with slot 8.
REQ-031 pm=8, cm=8 then pm=8, cm=0, back-to-back frames -> 8 outputs then 0 outputs; two frame_done pulses; no errors.
REQ-032 pm=8, cm=3 with valid_in low on alternate cycles -> same 3 words as REQ-030, each delayed per stall; acc unaffected by gaps.
REQ-033 sof on slot 5 of a pm=8 frame -> err_sof_early; no frame_done; new frame counted from that slot. A ninth slot without sof -> err_sof_late; the block enters IDLE.
REQ-034 sof with pm=4, cm=5 and with pm=0 -> cfg_err each time; no outputs; the block stays IDLE.
REQ-035 rst asserted at slot 4 of a frame -> all outputs 0 on the next cycle; later slots without sof produce nothing until the next sof.
